// File: rtl/isquare_pkg.sv
// Shared types and sizing constants for the isquare block.
package isquare_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      BCD  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam int unsigned X_W      = 8;
   localparam int unsigned SQ_W     = 16;
   localparam int unsigned BCD_W    = 20;
   localparam int unsigned MUL_ITER = 8;
   localparam int unsigned BCD_ITER = 16;

endpackage

// File: rtl/isquare_dabble_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
module dabble_adj (
   input  logic [3:0] d,
   output logic [3:0] q
);

   // Pre-shift correction so the following left shift carries correctly into the next digit
   always_comb begin
      q = d;
      if (d >= 4'd5) q = d + 4'd3;
   end

endmodule

// File: rtl/isquare.sv
// Sequential squarer: shift-add multiply of x by itself, then double-dabble
// conversion of the 16-bit product to five packed BCD digits.
module isquare #(
   parameter int unsigned X_W = isquare_pkg::X_W
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             start,
   input  logic [X_W-1:0]   x,
   output logic [2*X_W-1:0] sq,
   output logic [19:0]      sq_bcd,
   output logic             busy,
   output logic             done
);

   import isquare_pkg::*;

   localparam int unsigned SQW   = 2 * X_W;
   localparam int unsigned MUL_N = X_W;
   localparam int unsigned BCD_N = SQW;
   localparam int unsigned CNT_W = $clog2(BCD_N);
   localparam int unsigned NDIG  = BCD_W / 4;

   state_t            state;
   logic [X_W-1:0]    opnd;
   logic [SQW-1:0]    mcand;
   logic [SQW-1:0]    acc;
   logic [BCD_W-1:0]  bcd;
   logic [CNT_W-1:0]  cnt;

   logic [SQW-1:0]    acc_add;
   logic [SQW-1:0]    acc_rot;
   logic [BCD_W-1:0]  bcd_adj;
   logic [BCD_W-1:0]  bcd_next;

   for (genvar g = 0; g < NDIG; g++) begin : g_adj
      dabble_adj u_adj (
         .d (bcd[g*4 +: 4]),
         .q (bcd_adj[g*4 +: 4])
      );
   end

   // Next-value datapath for one multiply step and one double-dabble step.
   // The accumulator rotates during BCD so that after all BCD_N steps it is
   // back to the product, which is then published as sq.
   always_comb begin
      acc_add  = acc;
      if (opnd[0]) acc_add = acc + mcand;
      acc_rot  = {acc[SQW-2:0], acc[SQW-1]};
      bcd_next = {bcd_adj[BCD_W-2:0], acc[SQW-1]};
   end

   // Control FSM, iteration counter, datapath registers and result outputs
   always_ff @(posedge clk) begin
      if (!clr) begin
         state  <= IDLE;
         opnd   <= '0;
         mcand  <= '0;
         acc    <= '0;
         bcd    <= '0;
         cnt    <= '0;
         sq     <= '0;
         sq_bcd <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  opnd  <= x;
                  mcand <= SQW'(x);
                  acc   <= '0;
                  bcd   <= '0;
                  cnt   <= '0;
                  state <= MUL;
               end
            end
            MUL: begin
               acc   <= acc_add;
               mcand <= mcand << 1;
               opnd  <= opnd >> 1;
               if (cnt == CNT_W'(MUL_N - 1)) begin
                  cnt   <= '0;
                  state <= BCD;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            BCD: begin
               bcd <= bcd_next;
               acc <= acc_rot;
               if (cnt == CNT_W'(BCD_N - 1)) begin
                  cnt    <= '0;
                  sq     <= acc_rot;
                  sq_bcd <= bcd_next;
                  state  <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Status flags decoded from the registered state
   always_comb begin
      busy = (state == MUL) || (state == BCD);
      done = (state == DONE);
   end

endmodule

// File: tb/tb_isquare.sv
// Scoreboard bench for isquare: stimulus pushes expected results, a monitor
// pops and compares whenever done is seen.
module tb_isquare;

   logic        clk = 1'b0;
   logic        clr = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  x = '0;
   logic [15:0] sq;
   logic [19:0] sq_bcd;
   logic        busy;
   logic        done;

   isquare #(.X_W(8)) dut (
      .clk    (clk),
      .clr    (clr),
      .start  (start),
      .x      (x),
      .sq     (sq),
      .sq_bcd (sq_bcd),
      .busy   (busy),
      .done   (done)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [15:0] sq;
      logic [19:0] bcd;
      int unsigned due;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   function automatic logic [19:0] to_bcd(input int unsigned v);
      logic [19:0] r;
      int unsigned n;
      n = v;
      r = '0;
      for (int i = 0; i < 5; i++) begin
         r[i*4 +: 4] = 4'(n % 10);
         n = n / 10;
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding request
   always @(negedge clk) begin
      if (done === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("sq", 32'(sq), 32'(e.sq));
            check("sq_bcd", 32'(sq_bcd), 32'(e.bcd));
            check("done_cycle", cyc, e.due);
         end
      end
   end

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk);
      while ((busy !== 1'b0 || done !== 1'b0) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) check("idle_timeout", 32'd1, 32'd0);
   endtask

   // Issue one request; a result is expected unless the caller will abort it
   task automatic issue(input logic [7:0] v, input bit expect_done, output int unsigned acc_cyc);
      exp_t e;
      wait_idle();
      x = v;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      acc_cyc = cyc;
      x = 8'($urandom);
      if (expect_done) begin
         e.sq  = 16'(int'(v) * int'(v));
         e.bcd = to_bcd(int'(v) * int'(v));
         e.due = acc_cyc + 24;
         exp_q.push_back(e);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         check("done_timeout", 32'(exp_q.size()), 32'd0);
         exp_q.delete();
      end
      @(negedge clk);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_sq"}, 32'(sq), 32'd0);
      check({tag, "_bcd"}, 32'(sq_bcd), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_done"}, 32'(done), 32'd0);
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int unsigned a;
      int unsigned r;

      // Reset state, with start asserted to confirm reset wins
      start = 1'b1;
      x = 8'd77;
      repeat (3) @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      check_zero("reset");
      clr = 1'b1;

      // x = 0
      issue(8'd0, 1'b1, a);
      drain();

      // x = 255 with busy profile over cycles 1..25
      issue(8'd255, 1'b1, a);
      for (int k = 1; k <= 24; k++) begin
         @(negedge clk);
         check("busy_high", 32'(busy), 32'd1);
      end
      @(negedge clk);
      check("busy_low_done", 32'(busy), 32'd0);
      drain();
      repeat (3) @(negedge clk);
      check("sq_hold", 32'(sq), 32'd65025);
      check("bcd_hold", 32'(sq_bcd), 32'h65025);

      // Back-to-back with start held: 15 then 16, accepted 26 cycles apart
      wait_idle();
      x = 8'd15;
      start = 1'b1;
      @(posedge clk);
      #1;
      a = cyc;
      x = 8'd16;
      exp_q.push_back('{16'd225, 20'h00225, a + 24});
      exp_q.push_back('{16'd256, 20'h00256, a + 50});
      while (cyc < a + 26) @(posedge clk);
      #1;
      start = 1'b0;
      drain();

      // Second start at cycle 10 of a running request is ignored
      issue(8'd99, 1'b1, a);
      while (cyc < a + 9) @(posedge clk);
      #1;
      x = 8'd7;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      drain();
      repeat (30) @(negedge clk);

      // Reset at cycle 12 aborts a request with no done pulse
      issue(8'd200, 1'b0, a);
      while (cyc < a + 11) @(posedge clk);
      #1;
      clr = 1'b0;
      @(posedge clk);
      #1;
      clr = 1'b1;
      @(negedge clk);
      check_zero("midreset");
      repeat (30) @(negedge clk);
      issue(8'd3, 1'b1, a);
      drain();

      // Full sweep, then random operands
      for (int v = 0; v < 256; v++) issue(8'(v), 1'b1, a);
      drain();
      for (int k = 0; k < 40; k++) begin
         r = $urandom_range(255, 0);
         issue(8'(r), 1'b1, a);
      end
      drain();

      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/isquare.md
ISQUARE -- requirements
Module: isquare

Interface
REQ-001 The module SHALL have parameter X_W, default 8, meaning operand width in bits.
REQ-002 The module SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The module SHALL have port clr, input, 1, the reset: synchronous and active-low (clr=0 at a rising edge of clk resets the block).
REQ-004 The module SHALL have port start, input, 1, the request strobe, sampled only in IDLE.
REQ-005 The module SHALL have port x, input, X_W, the unsigned operand, latched when start is accepted.
REQ-006 The module SHALL have port sq, output, 2*X_W, the unsigned binary result x*x.
REQ-007 The module SHALL have port sq_bcd, output, 20, five packed BCD digits of sq, most significant digit in [19:16].
REQ-008 The module SHALL have port busy, output, 1, high in states MUL and BCD.
REQ-009 The module SHALL have port done, output, 1, a one-cycle pulse marking new valid sq and sq_bcd.

Function
REQ-010 The FSM SHALL have states IDLE, MUL, BCD and DONE.
REQ-011 In IDLE with start=1 at edge 0, the FSM SHALL latch x into an internal operand register and enter MUL.
REQ-012 MUL SHALL run exactly 8 shift-add iterations on edges 1..8: if the operand LSB is 1, add the shifted multiplicand to a 16-bit accumulator; shift multiplicand left and operand right; enter BCD at edge 8.
REQ-013 BCD SHALL run exactly 16 double-dabble iterations on edges 9..24: add 3 to every BCD digit >= 5, then shift left one bit, taking the accumulator MSB into bit 0; enter DONE at edge 24.
REQ-014 sq and sq_bcd SHALL be registered on the edge entering DONE and SHALL hold until the next DONE entry or reset.
REQ-015 done SHALL be 1 only in the single DONE cycle; DONE SHALL return to IDLE on the next edge.
REQ-016 Total latency SHALL be fixed: done high in the cycle following edge 24, independent of x.
REQ-017 start SHALL be ignored in MUL, BCD and DONE; no request is queued.
REQ-018 Changes on x after acceptance SHALL NOT affect the running computation.
REQ-019 Accumulator arithmetic SHALL be unsigned and 16 bits wide; 255*255=65025 SHALL fit without overflow.
REQ-020 sq_bcd SHALL never contain a digit greater than 9.
REQ-021 A start asserted continuously SHALL be accepted again on the first IDLE cycle after DONE.

Reset
REQ-022 With clr=0 at a rising edge, the FSM SHALL go to IDLE and sq, sq_bcd, busy and done SHALL become 0, including mid-operation.
REQ-023 Internal operand, accumulator, BCD shift register and iteration counter SHALL clear on reset.
REQ-024 A computation interrupted by reset SHALL produce no done pulse.
REQ-025 If clr=0 and start=1 occur together, reset SHALL take priority.

Structure
REQ-026 A shared package SHALL hold the state enum (IDLE, MUL, BCD, DONE) and the constants X_W=8, SQ_W=16, BCD_W=20, MUL_ITER=8 and BCD_ITER=16.
REQ-027 The block SHALL use one sub-module, dabble_adj: a combinational add-3-if->=5 applied to a 4-bit digit, instantiated five times.
REQ-028 The same iteration counter SHALL serve both MUL and BCD, reloaded at the state change.

Verification
REQ-029 Bench: reset, x=0, start -> done at cycle 25, sq=0, sq_bcd=0x00000.
REQ-030 Bench: x=255 -> sq=65025 (0xFE01), sq_bcd=0x65025, busy high for cycles 1..24.
REQ-031 Bench: x=15 then x=16 back-to-back with start held -> sq=225, sq_bcd=0x00225, then sq=256, sq_bcd=0x00256; the two done pulses 26 cycles apart.
REQ-032 Bench: start x=99, then pulse start with x=7 at cycle 10 -> second request ignored; sq=9801, sq_bcd=0x09801.
REQ-033 Bench: start x=200, clr=0 at cycle 12 -> all outputs 0 next cycle, no done; a new start with x=3 -> sq=9, sq_bcd=0x00009.
REQ-034 Bench: sweep x=0..255 -> sq matches x*x, sq_bcd matches decimal, done exactly once per request.
